// File: rtl/jtag_vji_scan_master.sv
// JTAG scan master: IR/DR scans into a virtual-JTAG target; accept-to-rsp = TCKs*2*TCK_HALF+1 clks, one command in flight.
// cmd_ready only in IDLE; `JTAG_VJI_TLR_RESET_EN adds a Test-Logic-Reset walk (5x TMS=1, 1x TMS=0) after reset.
module jtag_vji_scan_master #(
  parameter int IR_W     = 2,
  parameter int DR_W     = 38,
  parameter int TCK_HALF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  output logic [IR_W-1:0] rsp_ir,
  output logic [DR_W-1:0] rsp_dr,
  output logic            tck,
  output logic            tms,
  output logic            tdi,
  input  logic            tdo
);
  localparam int HW = $clog2(TCK_HALF) + 1;
  localparam int IW = $clog2(DR_W + 8);
  localparam logic [HW-1:0] H_LAST = HW'(TCK_HALF - 1);

  typedef enum logic [3:0] {
    IDLE, RESET_SEQ, IR_NAV, IR_SHIFT, IR_EXIT, DR_NAV, DR_SHIFT, DR_EXIT, DONE
  } state_t;

  state_t          state, ns;
  logic [HW-1:0]   hcnt;
  logic [IW-1:0]   idx, nidx, last;
  logic            step_last, ns_tms, do_dr;
  logic [IR_W-1:0] ir_sh;
  logic [DR_W-1:0] dr_sh;
`ifdef JTAG_VJI_TLR_RESET_EN
  logic            tlr_go;
`endif

  // Next TCK slot (state, index, TMS) taken at each tck falling edge
  always_comb begin
    last = '0;
    case (state)
      RESET_SEQ: last = IW'(5);
      IR_NAV:    last = IW'(3);
      IR_SHIFT:  last = IW'(IR_W - 1);
      IR_EXIT:   last = IW'(1);
      DR_NAV:    last = IW'(2);
      DR_SHIFT:  last = IW'(DR_W - 1);
      DR_EXIT:   last = IW'(1);
      default:   last = '0;
    endcase
    step_last = (idx == last);
    nidx      = step_last ? '0 : idx + 1'b1;
    ns        = state;
    if (step_last) begin
      case (state)
        RESET_SEQ: ns = IDLE;
        IR_NAV:    ns = IR_SHIFT;
        IR_SHIFT:  ns = IR_EXIT;
        IR_EXIT:   ns = do_dr ? DR_NAV : DONE;
        DR_NAV:    ns = DR_SHIFT;
        DR_SHIFT:  ns = DR_EXIT;
        DR_EXIT:   ns = DONE;
        default:   ns = state;
      endcase
    end
    case (ns)
      RESET_SEQ:                ns_tms = (nidx != IW'(5));
      IR_NAV:                   ns_tms = (nidx < IW'(2));
      IR_SHIFT:                 ns_tms = (nidx == IW'(IR_W - 1));
      IR_EXIT, DR_NAV, DR_EXIT: ns_tms = (nidx == '0);
      DR_SHIFT:                 ns_tms = (nidx == IW'(DR_W - 1));
      default:                  ns_tms = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef JTAG_VJI_TLR_RESET_EN
      state  <= RESET_SEQ;
      tlr_go <= 1'b0;
`else
      state  <= IDLE;
`endif
      hcnt      <= '0;
      idx       <= '0;
      do_dr     <= 1'b0;
      ir_sh     <= '0;
      dr_sh     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_ir    <= '0;
      rsp_dr    <= '0;
      tck       <= 1'b0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            do_dr     <= cmd_op[1];
            ir_sh     <= cmd_ir;
            dr_sh     <= cmd_dr;
            hcnt      <= '0;
            idx       <= '0;
            case (cmd_op)
              2'b00:   state <= DONE;
              2'b10:   begin state <= DR_NAV; tms <= 1'b1; end
              default: begin state <= IR_NAV; tms <= 1'b1; end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
`ifdef JTAG_VJI_TLR_RESET_EN
          // First edge after reset plays the role of an accept edge for the TLR walk
          if (!tlr_go) begin
            tlr_go <= 1'b1;
            tms    <= 1'b1;
            hcnt   <= '0;
          end else
`endif
          if (hcnt != H_LAST) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!tck) begin
              tck <= 1'b1;
              if (state == IR_SHIFT) rsp_ir <= (rsp_ir >> 1) | (IR_W'(tdo) << (IR_W - 1));
              if (state == DR_SHIFT) rsp_dr <= (rsp_dr >> 1) | (DR_W'(tdo) << (DR_W - 1));
            end else begin
              tck   <= 1'b0;
              state <= ns;
              idx   <= nidx;
              tms   <= ns_tms;
              tdi   <= 1'b0;
              if (ns == IR_SHIFT) begin
                tdi   <= ir_sh[0];
                ir_sh <= ir_sh >> 1;
              end
              if (ns == DR_SHIFT) begin
                tdi   <= dr_sh[0];
                dr_sh <= dr_sh >> 1;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_vji_scan_master.sv
// Bench for jtag_vji_scan_master: per-TCK TMS/TDI/TDO reference queue built from the TAP walk rules.
module tb_jtag_vji_scan_master;
  localparam int IR_W     = 2;
  localparam int DR_W     = 38;
  localparam int TCK_HALF = 2;
`ifdef JTAG_VJI_TLR_RESET_EN
  localparam bit TLR_MODE = 1'b1;
`else
  localparam bit TLR_MODE = 1'b0;
`endif

  logic            clk, reset, cmd_valid, cmd_ready, rsp_valid, tck, tms, tdi, tdo;
  logic [1:0]      cmd_op;
  logic [IR_W-1:0] cmd_ir, rsp_ir;
  logic [DR_W-1:0] cmd_dr, rsp_dr;

  jtag_vji_scan_master #(.IR_W(IR_W), .DR_W(DR_W), .TCK_HALF(TCK_HALF)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
    .rsp_ir(rsp_ir), .rsp_dr(rsp_dr), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        tms;
    logic        tdi;
    logic [1:0]  kind;   // 0 none, 1 IR shift bit, 2 DR shift bit
    logic [15:0] bi;
  } tck_t;

  tck_t            q[$];
  int              checks = 0, errors = 0;
  int              cyc = 0, since = 0, rises = 0, exp_lat = 0, rsp_cnt = 0;
  int              done_lat = 0, done_rises = 0, tdo_mode = 0;
  bit              pending = 1'b0;
  logic            prev_tck = 1'b0;
  logic [63:0]     log_tms = '0, done_log = '0;
  logic [IR_W-1:0] exp_ir = '0;
  logic [DR_W-1:0] exp_dr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic t, input logic d, input logic [1:0] kind, input int bi);
    tck_t e;
    e.tms = t; e.tdi = d; e.kind = kind; e.bi = 16'(bi);
    q.push_back(e);
  endtask

  task automatic model_ir(input logic [IR_W-1:0] v);
    push(1'b1, 1'b0, 2'd0, 0); push(1'b1, 1'b0, 2'd0, 0);
    push(1'b0, 1'b0, 2'd0, 0); push(1'b0, 1'b0, 2'd0, 0);
    for (int k = 0; k < IR_W; k++) push(k == IR_W - 1, v[k], 2'd1, k);
    push(1'b1, 1'b0, 2'd0, 0); push(1'b0, 1'b0, 2'd0, 0);
  endtask

  task automatic model_dr(input logic [DR_W-1:0] v);
    push(1'b1, 1'b0, 2'd0, 0); push(1'b0, 1'b0, 2'd0, 0); push(1'b0, 1'b0, 2'd0, 0);
    for (int k = 0; k < DR_W; k++) push(k == DR_W - 1, v[k], 2'd2, k);
    push(1'b1, 1'b0, 2'd0, 0); push(1'b0, 1'b0, 2'd0, 0);
  endtask

  // Single compare process: sampled on the falling clk edge, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      pending  = 1'b0;
      exp_ir   = '0;
      exp_dr   = '0;
      prev_tck = 1'b0;
      rises    = 0;
      log_tms  = '0;
    end else begin
      if (pending) begin cyc++; since++; end
      if (tck !== prev_tck) begin
        if (pending) chk("half_period", 64'(since), 64'(TCK_HALF));
        since = 0;
        if (tck) begin
          rises++;
          log_tms = {log_tms[62:0], tms};
          if (pending || !TLR_MODE) chk("tck_expected", 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            tck_t e;
            e = q.pop_front();
            chk("tms", 64'(tms), 64'(e.tms));
            chk("tdi", 64'(tdi), 64'(e.tdi));
            if (e.kind == 2'd1) exp_ir[e.bi] = tdo;
            if (e.kind == 2'd2) exp_dr[e.bi] = tdo;
          end
        end
        prev_tck = tck;
      end
      if (rsp_valid) begin
        chk("rsp_expected", 64'(pending), 64'd1);
        if (pending) begin
          chk("latency", 64'(cyc - 1), 64'(exp_lat));
          chk("rsp_ir", 64'(rsp_ir), 64'(exp_ir));
          chk("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
          chk("tcks_left", 64'(q.size()), 64'd0);
          chk("end_pins", 64'({tck, tms, tdi}), 64'd0);
          done_lat   = cyc - 1;
          done_rises = rises;
          done_log   = log_tms;
          rsp_cnt++;
          pending    = 1'b0;
        end
      end else if (pending) begin
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      end
      if (!pending && !TLR_MODE) chk("idle_pins", 64'({tck, tms, tdi}), 64'd0);
      if (!tck) begin
        case (tdo_mode)
          0:       tdo = 1'($urandom_range(0, 1));
          1:       tdo = 1'b0;
          2:       tdo = 1'b1;
          default: tdo = tdi;
        endcase
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_op[0]) model_ir(cmd_ir);
        if (cmd_op[1]) model_dr(cmd_dr);
        exp_lat = q.size() * 2 * TCK_HALF + 1;
        pending = 1'b1;
        cyc     = 0;
        since   = -1;
        rises   = 0;
        log_tms = '0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [IR_W-1:0] ir,
                      input logic [DR_W-1:0] dr, input bit keep);
    int i;
    @(posedge clk); #1;
    cmd_op = op; cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    i = 0;
    while (!cmd_ready && i < 1000) begin @(posedge clk); #1; i++; end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n0, i;
    n0 = rsp_cnt;
    i  = 0;
    while (rsp_cnt == n0 && i < budget) begin @(posedge clk); i++; end
    chk("rsp_arrived", 64'(rsp_cnt != n0), 64'd1);
  endtask

  task automatic release_reset();
    int i;
    @(posedge clk); #1;
    reset = 1'b0;
    i = 0;
`ifdef JTAG_VJI_TLR_RESET_EN
    while (!cmd_ready && i < 200) begin @(posedge clk); #1; i++; end
    chk("tlr_tck_count", 64'(rises), 64'd6);
    chk("tlr_tms_pattern", log_tms, 64'h3E);
`else
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int saved;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ir = '0; cmd_dr = '0; tdo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tck", 64'(tck), 64'd0);
    chk("reset_tms", 64'(tms), 64'd0);
    chk("reset_tdi", 64'(tdi), 64'd0);
    chk("reset_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_ir", 64'(rsp_ir), 64'd0);
    chk("reset_rsp_dr", 64'(rsp_dr), 64'd0);
    release_reset();

    // DR only with TDO looped back from TDI
    tdo_mode = 3;
    send(2'b10, 2'b00, 38'h2A_5A5A_A5A5, 1'b0);
    wait_rsp(400);
    chk("dr_loop_value", 64'(rsp_dr), 64'h2A_5A5A_A5A5);
    chk("dr_latency", 64'(done_lat), 64'd173);
    chk("dr_tck_count", 64'(done_rises), 64'd43);
    chk("dr_tms_pattern", done_log, 64'h0000_0400_0000_0006);

    // IR only, TDO tied high, DR result must be left alone
    tdo_mode = 2;
    send(2'b01, 2'b10, 38'h15_1234_5678, 1'b0);
    wait_rsp(400);
    chk("ir_value", 64'(rsp_ir), 64'h3);
    chk("ir_dr_kept", 64'(rsp_dr), 64'h2A_5A5A_A5A5);
    chk("ir_tms_pattern", done_log, 64'hC6);
    chk("ir_latency", 64'(done_lat), 64'd33);

    // IR then DR back to back, TDO tied low
    tdo_mode = 1;
    send(2'b11, 2'b01, '0, 1'b0);
    wait_rsp(400);
    chk("both_ir", 64'(rsp_ir), 64'd0);
    chk("both_dr", 64'(rsp_dr), 64'd0);
    chk("both_tck_count", 64'(done_rises), 64'd51);
    chk("both_tms_pattern", done_log, 64'h0006_3400_0000_0006);
    chk("both_latency", 64'(done_lat), 64'd205);

    // cmd_valid held across completion; the follow-up no-op is taken after DONE
    tdo_mode = 0;
    send(2'b01, 2'b11, '0, 1'b1);
    cmd_op = 2'b00;
    wait_rsp(400);
    chk("held_first_latency", 64'(done_lat), 64'd33);
    #1 cmd_valid = 1'b0;
    wait_rsp(20);
    chk("noop_latency", 64'(done_lat), 64'd1);
    chk("noop_tcks", 64'(done_rises), 64'd0);

    for (int n = 0; n < 16; n++) begin
      tdo_mode = int'($urandom_range(0, 3));
      send(2'($urandom_range(0, 3)), IR_W'($urandom), {6'($urandom), 32'($urandom)}, 1'b0);
      wait_rsp(400);
    end

    // Reset in the middle of a DR scan
    tdo_mode = 0;
    send(2'b10, '0, {6'($urandom), 32'($urandom)}, 1'b0);
    for (int i = 0; i < 400 && rises < 20; i++) @(posedge clk);
    chk("reached_tck20", 64'(rises >= 20), 64'd1);
    saved = rsp_cnt;
    #1 reset = 1'b1;
    #1;
    chk("abort_pins", 64'({tck, tms, tdi}), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd0);
    repeat (3) @(posedge clk);
    release_reset();
    repeat (50) @(posedge clk);
    #1;
    chk("abort_no_rsp", 64'(rsp_cnt), 64'(saved));
    chk("abort_rsp_dr", 64'(rsp_dr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
